// File: rtl/adder_tree_pkg.sv
// Shared elaboration helpers for the streaming adder tree: stage count, widths,
// pipeline depth and the rule deciding which adder levels are followed by a register rank.
package adder_tree_pkg;

  function automatic int num_stages(input int num_inputs);
    return $clog2(num_inputs);
  endfunction

  function automatic int full_width(input int input_width, input int num_inputs);
    return input_width + $clog2(num_inputs);
  endfunction

  function automatic int latency(input int num_inputs, input int reg_every);
    int ns = $clog2(num_inputs);
    return (ns + reg_every - 1) / reg_every;
  endfunction

  // Level s (1-based) gets a register after every reg_every levels, and always after the last.
  function automatic bit reg_after(input int s, input int num_inputs, input int reg_every);
    return ((s % reg_every) == 0) || (s == $clog2(num_inputs));
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One adder-tree level: pairwise sign-extended sums, optionally registered with a valid bit.
// Registered variant loads data and valid only on en; unregistered variant is pure combinational.
module adder_tree_level #(
  parameter int IN_W = 8,
  parameter int N_IN = 2,
  parameter bit REG  = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   in_vld,
  input  logic signed [IN_W-1:0] in_dat [N_IN],
  output logic                   out_vld,
  output logic signed [IN_W:0]   out_dat [N_IN/2]
);

  logic signed [IN_W:0] sum [N_IN/2];

  always_comb begin
    for (int i = 0; i < N_IN/2; i++) begin
      sum[i] = {in_dat[2*i][IN_W-1], in_dat[2*i]} + {in_dat[2*i+1][IN_W-1], in_dat[2*i+1]};
    end
  end

  if (REG) begin : g_reg
    logic                 vld_q, vld_d;
    logic signed [IN_W:0] dat_q [N_IN/2];
    logic signed [IN_W:0] dat_d [N_IN/2];

    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (en) begin
        vld_d = in_vld;
        dat_d = sum;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_q <= 1'b0;
        for (int i = 0; i < N_IN/2; i++) dat_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, resetn, en};
    assign out_vld    = in_vld;
    assign out_dat    = sum;
  end

endmodule

// File: rtl/adder_tree_stream.sv
// Pipelined signed adder tree with valid/ready; ceil(NUM_STAGES/REG_EVERY) cycles, all ranks stall together.
// in_ready = !out_valid || out_ready; ADDER_TREE_STREAM_SAT_EN selects saturation instead of wrap.
module adder_tree_stream
  import adder_tree_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int NUM_INPUTS  = 53,
  parameter int REG_EVERY   = 1,
  parameter int OUT_WIDTH   = INPUT_WIDTH + $clog2(NUM_INPUTS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [INPUT_WIDTH-1:0] in_data [NUM_INPUTS],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_sat
);

  localparam int NS = num_stages(NUM_INPUTS);
  localparam int FW = full_width(INPUT_WIDTH, NUM_INPUTS);

  logic                        adv;
  logic                        last_vld;
  logic signed [FW-1:0]        full_sum;
  logic signed [OUT_WIDTH-1:0] conv_dat;
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  for (genvar s = 1; s <= NS; s++) begin : g_lvl
    localparam int IW = INPUT_WIDTH + s - 1;
    localparam int NI = 2 ** (NS - s + 1);

    logic signed [IW-1:0] din [NI];
    logic                 din_vld;
    logic signed [IW:0]   dout [NI/2];
    logic                 dout_vld;

    if (s == 1) begin : g_src
      for (genvar i = 0; i < NI; i++) begin : g_pad
        if (i < NUM_INPUTS) begin : g_op
          assign din[i] = in_data[i];
        end else begin : g_zero
          assign din[i] = '0;
        end
      end
      assign din_vld = in_valid;
    end else begin : g_src
      assign din     = g_lvl[s-1].dout;
      assign din_vld = g_lvl[s-1].dout_vld;
    end

    // The last level stays combinational: its rank is the output register below.
    adder_tree_level #(
      .IN_W (IW),
      .N_IN (NI),
      .REG  ((s < NS) && reg_after(s, NUM_INPUTS, REG_EVERY))
    ) u_level (
      .clk     (clk),
      .resetn  (resetn),
      .en      (adv),
      .in_vld  (din_vld),
      .in_dat  (din),
      .out_vld (dout_vld),
      .out_dat (dout)
    );
  end

  assign full_sum = g_lvl[NS].dout[0];
  assign last_vld = g_lvl[NS].dout_vld;

`ifdef ADDER_TREE_STREAM_SAT_EN
  localparam logic signed [FW-1:0] SAT_MAX = {{(FW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [FW-1:0] SAT_MIN = {{(FW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic conv_sat;
  logic out_sat_q, out_sat_d;

  always_comb begin
    conv_sat = 1'b0;
    conv_dat = full_sum[OUT_WIDTH-1:0];
    if (full_sum > SAT_MAX) begin
      conv_dat = SAT_MAX[OUT_WIDTH-1:0];
      conv_sat = 1'b1;
    end else if (full_sum < SAT_MIN) begin
      conv_dat = SAT_MIN[OUT_WIDTH-1:0];
      conv_sat = 1'b1;
    end
  end

  always_comb begin
    out_sat_d = out_sat_q;
    if (adv) out_sat_d = conv_sat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) out_sat_q <= 1'b0;
    else         out_sat_q <= out_sat_d;
  end

  assign out_sat = out_sat_q;
`else
  assign conv_dat = full_sum[OUT_WIDTH-1:0];
  assign out_sat  = 1'b0;

  if (OUT_WIDTH < FW) begin : g_wrap_hi
    logic unused_hi;
    assign unused_hi = ^full_sum[FW-1:OUT_WIDTH];
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      out_valid_d = last_vld;
      out_data_d  = conv_dat;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_adder_tree_stream.sv
// Four adder_tree_stream instances (5 x 8-bit operands) sharing one input stream, each checked
// against a per-instance queue of reference sums.
module tb_adder_tree_stream;

  localparam int NI = 5;
  localparam int IW = 8;
  localparam int NK = 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 in_valid;
  logic signed [IW-1:0] in_data [NI];
  logic                 out_rdy [NK];
  logic                 ir      [NK];
  logic                 ov      [NK];
  logic                 osat    [NK];
  longint               od      [NK];
  int                   pend    [NK];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_sum();
    longint s = 0;
    foreach (in_data[i]) s += longint'(in_data[i]);
    return s;
  endfunction

  function automatic longint exp_val(input longint s, input int ow);
    longint span = longint'(1) <<< ow;
    longint mx   = span / 2 - 1;
`ifdef ADDER_TREE_STREAM_SAT_EN
    if (s > mx) return mx;
    if (s < -mx - 1) return -mx - 1;
    return s;
`else
    longint r = s % span;
    if (r > mx) r -= span;
    if (r < -mx - 1) r += span;
    return r;
`endif
  endfunction

  function automatic longint exp_sat(input longint s, input int ow);
`ifdef ADDER_TREE_STREAM_SAT_EN
    longint mx = (longint'(1) <<< (ow - 1)) - 1;
    return (s > mx || s < -mx - 1) ? 1 : 0;
`else
    return (ow > 0) ? 0 : s;
`endif
  endfunction

  for (genvar k = 0; k < NK; k++) begin : g_dut
    localparam int OW = (k == 0) ? 8 : 11;
    localparam int RE = (k == 2) ? 2 : ((k == 3) ? 3 : 1);

    logic signed [OW-1:0] od_raw;
    longint               q_sum [$];
    longint               s_exp;

    adder_tree_stream #(
      .INPUT_WIDTH (IW),
      .NUM_INPUTS  (NI),
      .REG_EVERY   (RE),
      .OUT_WIDTH   (OW)
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (ir[k]),
      .in_data   (in_data),
      .out_valid (ov[k]),
      .out_ready (out_rdy[k]),
      .out_data  (od_raw),
      .out_sat   (osat[k])
    );

    assign od[k] = longint'(od_raw);

    always @(negedge clk) begin
      if (!resetn) begin
        q_sum.delete();
      end else begin
        if (ov[k] && out_rdy[k]) begin
          if (q_sum.size() == 0) begin
            chk($sformatf("spurious_out_k%0d", k), 1, 0);
          end else begin
            s_exp = q_sum.pop_front();
            chk($sformatf("sum_k%0d", k), od[k], exp_val(s_exp, OW));
            chk($sformatf("sat_k%0d", k), longint'(osat[k]), exp_sat(s_exp, OW));
          end
        end
        if (in_valid && ir[k]) q_sum.push_back(ref_sum());
      end
      pend[k] = q_sum.size();
    end
  end

  task automatic set_ops(input int a, input int b, input int c, input int d, input int e);
    int v [NI];
    v = '{a, b, c, d, e};
    foreach (in_data[i]) in_data[i] = IW'(v[i]);
  endtask

  task automatic rand_ops();
    foreach (in_data[i]) in_data[i] = IW'($urandom_range(0, 255));
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    foreach (out_rdy[k]) out_rdy[k] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < NK; k++) chk($sformatf("%s_pending_k%0d", tag, k), pend[k], 0);
  endtask

  task automatic latency_test(input int v, input longint exp0, input longint sat0);
    int lat [NK];
    int exp_lat [NK] = '{3, 3, 2, 1};
    foreach (lat[k]) lat[k] = -1;
    set_ops(v, v, v, v, v);
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (ov[k] && lat[k] < 0) begin
          lat[k] = c;
          if (k == 0) begin
            chk("lat_data_k0", od[0], exp0);
            chk("lat_sat_k0", longint'(osat[0]), sat0);
          end
        end
      end
      @(posedge clk) #1;
    end
    for (int k = 0; k < NK; k++) chk($sformatf("latency_k%0d", k), lat[k], exp_lat[k]);
  endtask

  task automatic stream_test();
    int first = -1;
    int last  = -1;
    int n     = 0;
    set_ops(1, -2, 3, -4, 5);
    in_valid = 1'b1;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 25; c++) begin
          @(negedge clk);
          if (ov[1]) begin
            if (first < 0) first = c;
            last = c;
            n++;
            chk("stream_val_k1", od[1], 3);
          end
        end
      end
    join
    chk("stream_count_k1", n, 10);
    chk("stream_span_k1", last - first + 1, 10);
    @(posedge clk) #1;
  endtask

  task automatic backpressure_test();
    int w = 0;
    set_ops(1, -2, 3, -4, 5);
    in_valid = 1'b1;
    while (!ov[0] && w < 10) begin
      @(posedge clk) #1;
      w++;
    end
    chk("bp_first_valid_k0", longint'(ov[0]), 1);
    out_rdy[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready_k0", longint'(ir[0]), 0);
      chk("bp_hold_valid_k0", longint'(ov[0]), 1);
      chk("bp_hold_data_k0", od[0], 3);
      @(posedge clk) #1;
    end
    out_rdy[0] = 1'b1;
    repeat (6) begin
      rand_ops();
      @(posedge clk) #1;
    end
    drain("bp");
  endtask

  initial begin
    int n_stale;
    resetn   = 1'b0;
    in_valid = 1'b0;
    foreach (in_data[i]) in_data[i] = '0;
    foreach (out_rdy[k]) out_rdy[k] = 1'b1;

    #12;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("rst_valid_k%0d", k), longint'(ov[k]), 0);
      chk($sformatf("rst_data_k%0d", k), od[k], 0);
      chk($sformatf("rst_sat_k%0d", k), longint'(osat[k]), 0);
      chk($sformatf("rst_in_ready_k%0d", k), longint'(ir[k]), 1);
    end
    @(posedge clk) #1;
    resetn = 1'b1;
    chk("post_rst_in_ready_k0", longint'(ir[0]), 1);

`ifdef ADDER_TREE_STREAM_SAT_EN
    latency_test(127, 127, 1);
    latency_test(-128, -128, 1);
`else
    latency_test(127, 123, 0);
    latency_test(-128, -128, 0);
`endif

    stream_test();
    backpressure_test();

    for (int n = 0; n < 1000; n++) begin
      rand_ops();
      in_valid = ($urandom_range(0, 4) != 0);
      foreach (out_rdy[k]) out_rdy[k] = ($urandom_range(0, 3) != 0);
      @(posedge clk) #1;
    end
    drain("rand");

    foreach (out_rdy[k]) out_rdy[k] = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      rand_ops();
      @(posedge clk) #1;
    end
    resetn   = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("midrst_valid_k%0d", k), longint'(ov[k]), 0);
      chk($sformatf("midrst_data_k%0d", k), od[k], 0);
      chk($sformatf("midrst_in_ready_k%0d", k), longint'(ir[k]), 1);
    end
    @(posedge clk) #1;
    @(posedge clk) #1;
    resetn  = 1'b1;
    n_stale = 0;
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) if (ov[k]) n_stale++;
    end
    chk("no_stale_after_rst", n_stale, 0);
    @(posedge clk) #1;

`ifdef ADDER_TREE_STREAM_SAT_EN
    latency_test(127, 127, 1);
`else
    latency_test(127, 123, 0);
`endif
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
